// File: rtl/vid_pkg.sv
// Shared definitions for the video line fetcher: FSM states, address step
// and default sizing.
package vid_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        CAPTURE   = 3'd4
    } vid_state_e;

    localparam logic [21:0] ADDR_STEP            = 22'd4;
    localparam int          DEF_FETCHES_PER_LINE = 16;
    localparam int          DEF_FIFO_DEPTH       = 8;

endpackage

// File: rtl/vid_fetch_if.sv
// SDRAM video-read port and pixel-shifter port of the line fetcher.
// rdv is a request held high until the controller acknowledges it by raising
// memvidbusy; the word pair is taken on the first cycle memvidbusy falls again.
interface vid_fetch_if;
    logic [21:0] vaddr;
    logic        rdv;
    logic        memvidbusy;
    logic [15:0] odata;
    logic [15:0] odata2;
    logic        pix_rd;
    logic [31:0] pix_data;
    logic        pix_empty;

    modport master (
        output vaddr, rdv, pix_data, pix_empty,
        input  memvidbusy, odata, odata2, pix_rd
    );

    modport slave (
        input  vaddr, rdv, pix_data, pix_empty,
        output memvidbusy, odata, odata2, pix_rd
    );
endinterface

// File: rtl/vid_fifo.sv
// Synchronous FIFO with flush and a registered head word, so the entry at the
// read pointer is presented directly from a flop.
module vid_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && !flush && (count_q != '0);
        do_push  = push && !flush && ((count_q != CNT_FULL) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
            else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
        end
        // A word written into the slot that becomes the head must bypass the array.
        if (count_d == '0)
            head_d = '0;
        else if (do_push && (wr_ptr_q == rd_ptr_d))
            head_d = din;
        else
            head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head  = head_q;
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/vid_fetch.sv
// Video line fetcher: issues one SDRAM word-pair read at a time for a display
// line and queues the pairs for the pixel shifter.
module vid_fetch
    import vid_pkg::*;
#(
    parameter int FETCHES_PER_LINE = DEF_FETCHES_PER_LINE,
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [21:0] line_base,
    output logic        underrun,
    output vid_state_e  state_o,
    vid_fetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]    FETCH_CNT = 8'(FETCHES_PER_LINE);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    vid_state_e    state_q, state_d;
    logic [21:0]   cur_addr_q, cur_addr_d;
    logic [21:0]   vaddr_q, vaddr_d;
    logic [21:0]   pend_base_q, pend_base_d;
    logic [7:0]    remaining_q, remaining_d;
    logic          rdv_q, rdv_d;
    logic          discard_q, discard_d;
    logic          underrun_q, underrun_d;
    logic          push, pop, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [21:0]   base_aligned;

    assign base_aligned = line_base & ~22'h3;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        vaddr_d     = vaddr_q;
        discard_d   = discard_q;
        pend_base_d = pend_base_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (line_start) begin
                    cur_addr_d  = base_aligned;
                    remaining_d = FETCH_CNT;
                end else if ((remaining_q != '0) && (fifo_count < DEPTH_CNT)) begin
                    state_d = REQ;
                    vaddr_d = cur_addr_q;
                end
            end
            REQ:       state_d = WAIT_BUSY;
            WAIT_BUSY: if (bus.memvidbusy)  state_d = WAIT_DONE;
            WAIT_DONE: if (!bus.memvidbusy) state_d = CAPTURE;
            CAPTURE: begin
                state_d   = IDLE;
                discard_d = 1'b0;
                if (line_start) begin
                    cur_addr_d  = base_aligned;
                    remaining_d = FETCH_CNT;
                end else if (discard_q) begin
                    cur_addr_d  = pend_base_q;
                    remaining_d = FETCH_CNT;
                end else begin
                    push        = 1'b1;
                    cur_addr_d  = cur_addr_q + ADDR_STEP;
                    remaining_d = remaining_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new line arriving mid-access lets the access finish but drops its data.
        if (line_start && (state_q inside {REQ, WAIT_BUSY, WAIT_DONE})) begin
            discard_d   = 1'b1;
            pend_base_d = base_aligned;
        end
        rdv_d = (state_d == REQ) || (state_d == WAIT_BUSY);
    end

    assign pop        = bus.pix_rd && !fifo_empty;
    assign underrun_d = underrun_q || (bus.pix_rd && fifo_empty && !line_start);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            vaddr_q     <= '0;
            pend_base_q <= '0;
            remaining_q <= '0;
            rdv_q       <= 1'b0;
            discard_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            vaddr_q     <= vaddr_d;
            pend_base_q <= pend_base_d;
            remaining_q <= remaining_d;
            rdv_q       <= rdv_d;
            discard_q   <= discard_d;
            underrun_q  <= underrun_d;
        end
    end

    vid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (line_start),
        .push  (push),
        .pop   (pop),
        .din   ({bus.odata2, bus.odata}),
        .head  (bus.pix_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.vaddr     = vaddr_q;
    assign bus.rdv       = rdv_q;
    assign bus.pix_empty = fifo_empty;
    assign underrun      = underrun_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_vid_fetch.sv
// Directed bench for vid_fetch: a 4-fetch/8-deep unit and a 16-fetch/2-deep
// unit share stimulus; sel chooses which one is observed.
module tb_vid_fetch;
    import vid_pkg::*;

    logic        clk = 1'b0;
    logic        reset, line_start, memvidbusy, pix_rd, sel;
    logic [21:0] line_base;
    logic [15:0] odata, odata2;
    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_q[$];
    logic [21:0] a;

    vid_fetch_if bus_a ();
    vid_fetch_if bus_b ();
    logic        underrun_a, underrun_b;
    vid_state_e  state_a, state_b;

    assign bus_a.memvidbusy = memvidbusy;
    assign bus_a.odata      = odata;
    assign bus_a.odata2     = odata2;
    assign bus_a.pix_rd     = pix_rd;
    assign bus_b.memvidbusy = memvidbusy;
    assign bus_b.odata      = odata;
    assign bus_b.odata2     = odata2;
    assign bus_b.pix_rd     = pix_rd;

    logic        rdv, pix_empty, underrun;
    logic [21:0] vaddr;
    logic [31:0] pix_data;
    logic [2:0]  st;
    assign rdv       = sel ? bus_b.rdv       : bus_a.rdv;
    assign vaddr     = sel ? bus_b.vaddr     : bus_a.vaddr;
    assign pix_data  = sel ? bus_b.pix_data  : bus_a.pix_data;
    assign pix_empty = sel ? bus_b.pix_empty : bus_a.pix_empty;
    assign underrun  = sel ? underrun_b      : underrun_a;
    assign st        = sel ? state_b         : state_a;

    vid_fetch #(.FETCHES_PER_LINE(4), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .reset(reset), .line_start(line_start), .line_base(line_base),
        .underrun(underrun_a), .state_o(state_a), .bus(bus_a)
    );

    vid_fetch #(.FETCHES_PER_LINE(16), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .reset(reset), .line_start(line_start), .line_base(line_base),
        .underrun(underrun_b), .state_o(state_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Line_start and pix_rd are held during the last reset cycle; reset must win.
    task automatic do_reset();
        reset = 1'b1; line_start = 1'b0; pix_rd = 1'b0; memvidbusy = 1'b0;
        step();
        line_start = 1'b1; pix_rd = 1'b1; line_base = 22'h000100;
        step();
        reset = 1'b0; line_start = 1'b0; pix_rd = 1'b0;
        step();
        exp_q.delete();
    endtask

    task automatic pulse_line(input logic [21:0] base);
        line_start = 1'b1; line_base = base;
        step();
        line_start = 1'b0;
    endtask

    task automatic serve(input int stall, input int busy_len, input logic [15:0] d0,
                         input logic [15:0] d1, input logic mid_ls,
                         input logic [21:0] mid_base, output logic [21:0] addr);
        int n;
        n = 0;
        while (rdv !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check_eq("rdv_seen", 32'(rdv), 32'd1);
        addr = vaddr;
        if (rdv !== 1'b1) return;
        for (int i = 0; i < stall; i++) begin
            step();
            check_eq("rdv_hold", 32'(rdv), 32'd1);
        end
        odata = d0; odata2 = d1; memvidbusy = 1'b1;
        for (int i = 0; i < busy_len; i++) begin
            line_start = mid_ls && (i == 2);
            if (line_start) line_base = mid_base;
            step();
            if (i == 0) check_eq("rdv_drop", 32'(rdv), 32'd0);
        end
        line_start = 1'b0; memvidbusy = 1'b0;
        if (mid_ls) exp_q.delete();
        else exp_q.push_back({d1, d0});
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) e = '0;
        else e = exp_q.pop_front();
        check_eq({tag, "_nonempty"}, 32'(pix_empty), 32'd0);
        check_eq({tag, "_data"}, pix_data, e);
        pix_rd = 1'b1;
        step();
        pix_rd = 1'b0;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (rdv === 1'b1) hits++;
        end
        check_eq(tag, 32'(hits), 32'd0);
    endtask

    initial begin
        sel = 1'b0; reset = 1'b1; line_start = 1'b0; line_base = '0;
        memvidbusy = 1'b0; odata = '0; odata2 = '0; pix_rd = 1'b0; a = '0;

        // Reset values, and no request without a line_start after reset.
        do_reset();
        check_eq("rst_rdv", 32'(rdv), 32'd0);
        check_eq("rst_vaddr", 32'(vaddr), 32'd0);
        check_eq("rst_empty", 32'(pix_empty), 32'd1);
        check_eq("rst_data", pix_data, 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        check_eq("rst_state", 32'(st), 32'(IDLE));
        expect_quiet("rst_quiet", 12);

        // Full line of 4 fetches, low address bits ignored, FIFO never drained.
        pulse_line(22'h000103);
        serve(1, 8, 16'h1234, 16'hABCD, 1'b0, '0, a); check_eq("line_addr0", 32'(a), 32'h100);
        serve(1, 8, 16'h1111, 16'h2222, 1'b0, '0, a); check_eq("line_addr1", 32'(a), 32'h104);
        serve(1, 8, 16'h3333, 16'h4444, 1'b0, '0, a); check_eq("line_addr2", 32'(a), 32'h108);
        serve(1, 8, 16'h5555, 16'h6666, 1'b0, '0, a); check_eq("line_addr3", 32'(a), 32'h10C);
        repeat (4) step();
        check_eq("pair_order", pix_data, 32'hABCD1234);
        check_eq("line_idle", 32'(st), 32'(IDLE));
        expect_quiet("line_done_quiet", 20);
        repeat (4) pop_check("line_pop");
        check_eq("line_drained", 32'(pix_empty), 32'd1);

        // Slow acknowledge, then a new line during WAIT_DONE discards and flushes.
        do_reset();
        pulse_line(22'h000800);
        serve(5, 8, 16'h0A0A, 16'h0B0B, 1'b0, '0, a); check_eq("stall_addr", 32'(a), 32'h800);
        serve(1, 8, 16'hDEAD, 16'hBEEF, 1'b1, 22'h002000, a); check_eq("disc_addr", 32'(a), 32'h804);
        repeat (4) step();
        check_eq("disc_flushed", 32'(pix_empty), 32'd1);
        serve(1, 8, 16'h7777, 16'h8888, 1'b0, '0, a); check_eq("new_base", 32'(a), 32'h2000);
        repeat (4) step();
        check_eq("new_head", pix_data, 32'h88887777);
        // Flush and pop in the same cycle: flush wins, no underrun.
        line_start = 1'b1; pix_rd = 1'b1; line_base = 22'h003000;
        step();
        line_start = 1'b0; pix_rd = 1'b0;
        check_eq("flush_pop_empty", 32'(pix_empty), 32'd1);
        check_eq("flush_pop_no_underrun", 32'(underrun), 32'd0);

        // Underrun is sticky; address wraps at the top of the 22-bit space.
        do_reset();
        line_start = 1'b1; pix_rd = 1'b1; line_base = 22'h3FFFFC;
        step();
        line_start = 1'b0;
        check_eq("empty_flush_no_underrun", 32'(underrun), 32'd0);
        step();
        pix_rd = 1'b0;
        check_eq("underrun_set", 32'(underrun), 32'd1);
        serve(1, 4, 16'h0001, 16'h0002, 1'b0, '0, a); check_eq("wrap_addr0", 32'(a), 32'h3FFFFC);
        serve(1, 4, 16'h0003, 16'h0004, 1'b0, '0, a); check_eq("wrap_addr1", 32'(a), 32'h000000);
        pulse_line(22'h000000);
        check_eq("underrun_sticky", 32'(underrun), 32'd1);
        do_reset();
        check_eq("underrun_cleared", 32'(underrun), 32'd0);

        // Two-entry FIFO: fetching stops when full and resumes after one pop.
        sel = 1'b1;
        do_reset();
        pulse_line(22'h000400);
        serve(1, 4, 16'hC001, 16'hC002, 1'b0, '0, a); check_eq("full_addr0", 32'(a), 32'h400);
        serve(1, 4, 16'hC003, 16'hC004, 1'b0, '0, a); check_eq("full_addr1", 32'(a), 32'h404);
        repeat (4) step();
        expect_quiet("full_quiet", 20);
        check_eq("full_idle", 32'(st), 32'(IDLE));
        pop_check("full_pop");
        serve(1, 4, 16'hC005, 16'hC006, 1'b0, '0, a); check_eq("resume_addr", 32'(a), 32'h408);
        repeat (4) step();
        pop_check("resume_pop");
        pop_check("resume_pop");
        check_eq("resume_empty", 32'(pix_empty), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
